assembly_sequencer: RTL



---
 rtl/assembly_sequencer.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/assembly_sequencer.sv
// assembly_sequencer: two-pass text streamer feeding the assembler and capturing its instruction words into IMEM
package assembly_sequencer_pkg;
    typedef enum logic [1:0] {
        ASM_IDLE            = 2'd0,
        PC_MAPPING          = 2'd1,
        INSTRUCTION_MAPPING = 2'd2
    } assembler_state_t;
endpackage

module assembly_sequencer
    import assembly_sequencer_pkg::*;
#(
    parameter int CHAR_PER_LINE = 64,
    parameter int NUMBER_LINES  = 256,
    parameter int READ_LATENCY  = 2,
    parameter int CHAR_GAP      = 2,
    parameter int LINE_GAP      = 4,
    localparam int TA = $clog2(CHAR_PER_LINE * NUMBER_LINES) + 1,
    localparam int IA = $clog2(NUMBER_LINES),
    localparam int CW = IA + 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start,
    input  logic [TA-1:0]    text_len,
    output logic [TA-1:0]    text_addr,
    input  logic [7:0]       text_data,
    output assembler_state_t assembler_state,
    output logic             new_line,
    output logic             new_character,
    output logic [7:0]       incoming_character,
    input  logic             asm_error,
    input  logic             new_instruction,
    input  logic [31:0]      instruction,
    output logic             imem_we,
    output logic [IA-1:0]    imem_addr,
    output logic [31:0]      imem_data,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CW-1:0]    err_line,
    output logic [CW-1:0]    inst_count
);
    typedef enum logic [3:0] {
        S_IDLE, S_LINE_START, S_FETCH, S_WAIT_RD, S_EMIT,
        S_CHAR_WAIT, S_LINE_WAIT, S_PASS_END, S_DONE, S_ERROR
    } state_t;

    localparam logic [CW-1:0] LAST_LINE = CW'(NUMBER_LINES - 1);
    localparam logic [CW-1:0] MAX_INST  = CW'(NUMBER_LINES);
    localparam logic [7:0]    RD_LAST   = 8'(READ_LATENCY - 1);
    localparam logic [7:0]    CG_LAST   = 8'(CHAR_GAP - 1);
    localparam logic [7:0]    LG_LAST   = 8'(LINE_GAP - 1);

    state_t          r_state, w_state;
    logic            r_pass2, w_pass2;
    logic [TA-1:0]   r_char_ptr, w_char_ptr, w_ptr_inc;
    logic [TA-1:0]   r_len, w_len;
    logic [CW-1:0]   r_line_cnt, w_line_cnt;
    logic [7:0]      r_wait, w_wait, w_wait_inc;
    logic [7:0]      r_char, w_char;
    logic            r_imem_we, w_imem_we;
    logic [IA-1:0]   r_imem_addr, w_imem_addr;
    logic [31:0]     r_imem_data, w_imem_data;
    logic [CW-1:0]   r_inst_count, w_inst_count;
    logic [CW-1:0]   r_err_line, w_err_line;
    logic            w_active;

    // State and datapath registers; reset returns everything to an idle, cleared sequencer
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= S_IDLE;
            r_pass2      <= 1'b0;
            r_char_ptr   <= '0;
            r_len        <= '0;
            r_line_cnt   <= '0;
            r_wait       <= '0;
            r_char       <= '0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_data  <= '0;
            r_inst_count <= '0;
            r_err_line   <= '0;
        end else begin
            r_state      <= w_state;
            r_pass2      <= w_pass2;
            r_char_ptr   <= w_char_ptr;
            r_len        <= w_len;
            r_line_cnt   <= w_line_cnt;
            r_wait       <= w_wait;
            r_char       <= w_char;
            r_imem_we    <= w_imem_we;
            r_imem_addr  <= w_imem_addr;
            r_imem_data  <= w_imem_data;
            r_inst_count <= w_inst_count;
            r_err_line   <= w_err_line;
        end
    end

    // Next-state logic: character streaming per pass, then instruction capture and error override
    always_comb begin
        w_state      = r_state;
        w_pass2      = r_pass2;
        w_char_ptr   = r_char_ptr;
        w_len        = r_len;
        w_line_cnt   = r_line_cnt;
        w_wait       = r_wait;
        w_char       = r_char;
        w_imem_we    = 1'b0;
        w_imem_addr  = r_imem_addr;
        w_imem_data  = r_imem_data;
        w_inst_count = r_inst_count;
        w_err_line   = r_err_line;
        w_ptr_inc    = r_char_ptr + TA'(1);
        w_wait_inc   = r_wait + 8'd1;
        w_active     = r_state inside {S_LINE_START, S_FETCH, S_WAIT_RD, S_EMIT,
                                       S_CHAR_WAIT, S_LINE_WAIT, S_PASS_END};
        unique case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    w_inst_count = '0;
                    w_err_line   = '0;
                    w_char_ptr   = '0;
                    w_line_cnt   = '0;
                    w_pass2      = 1'b0;
                    w_len        = text_len;
                    w_state      = (text_len == '0) ? S_DONE : S_LINE_START;
                end
            end
            S_LINE_START: w_state = S_FETCH;
            S_FETCH: begin
                w_wait  = '0;
                w_state = S_WAIT_RD;
            end
            S_WAIT_RD: begin
                if (r_wait == RD_LAST) begin
                    w_wait = '0;
                    if (text_data == 8'h0D) begin
                        w_char_ptr = w_ptr_inc;
                        w_state    = (w_ptr_inc == r_len) ? S_LINE_WAIT : S_FETCH;
                    end else begin
                        w_char  = text_data;
                        w_state = S_EMIT;
                    end
                end else begin
                    w_wait = w_wait_inc;
                end
            end
            S_EMIT: begin
                w_char_ptr = w_ptr_inc;
                w_wait     = '0;
                w_state    = S_CHAR_WAIT;
            end
            S_CHAR_WAIT: begin
                if (r_wait == CG_LAST) begin
                    w_wait  = '0;
                    w_state = (r_char == 8'h0A || r_char_ptr == r_len) ? S_LINE_WAIT : S_FETCH;
                end else begin
                    w_wait = w_wait_inc;
                end
            end
            S_LINE_WAIT: begin
                if (r_wait == LG_LAST) begin
                    w_wait     = '0;
                    w_line_cnt = r_line_cnt + CW'(1);
                    if (r_char_ptr < r_len) begin
                        w_state    = (r_line_cnt == LAST_LINE) ? S_ERROR : S_LINE_START;
                        w_err_line = (r_line_cnt == LAST_LINE) ? MAX_INST : r_err_line;
                    end else begin
                        w_state = S_PASS_END;
                    end
                end else begin
                    w_wait = w_wait_inc;
                end
            end
            S_PASS_END: begin
                w_state    = r_pass2 ? S_DONE : S_LINE_START;
                w_char_ptr = r_pass2 ? r_char_ptr : '0;
                w_line_cnt = r_pass2 ? r_line_cnt : '0;
                w_pass2    = 1'b1;
            end
            default: w_state = S_IDLE;
        endcase
        if (w_active && asm_error) begin
            w_state    = S_ERROR;
            w_err_line = r_line_cnt;
        end else if (w_active && r_pass2 && new_instruction) begin
            if (r_inst_count == MAX_INST) begin
                w_state    = S_ERROR;
                w_err_line = r_line_cnt;
            end else begin
                w_imem_we    = 1'b1;
                w_imem_addr  = r_inst_count[IA-1:0];
                w_imem_data  = instruction;
                w_inst_count = r_inst_count + CW'(1);
            end
        end
    end

    assign text_addr          = r_char_ptr;
    assign new_line           = (r_state == S_LINE_START);
    assign new_character      = (r_state == S_EMIT);
    assign incoming_character = r_char;
    assign busy               = w_active;
    assign done               = (r_state == S_DONE);
    assign error              = (r_state == S_ERROR);
    assign assembler_state    = !w_active ? ASM_IDLE : (r_pass2 ? INSTRUCTION_MAPPING : PC_MAPPING);
    assign imem_we            = r_imem_we;
    assign imem_addr          = r_imem_addr;
    assign imem_data          = r_imem_data;
    assign inst_count         = r_inst_count;
    assign err_line           = r_err_line;
endmodule
